// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit game-object layer.
package fruit_pkg;

  typedef struct packed {
    logic               active;
    logic signed [11:0] x;
    logic signed [10:0] y;
    logic signed [5:0]  vx;
    logic signed [5:0]  vy;
    logic [11:0]        colour;
  } fruit_t;

  typedef enum logic {IDLE, UPDATE} state_t;

  localparam logic [11:0] TRANSPARENT = 12'h000;
  localparam logic [11:0] COLOR_FIX   = 12'h111;

  function automatic logic [12:0] abs13(input logic signed [12:0] v);
    return v[12] ? 13'(-v) : 13'(v);
  endfunction

endpackage

// File: rtl/fruit_circle_hit.sv
// Per-slot circle coverage: stage 1 registers the pixel offset, stage 2 is
// the squared-distance compare consumed by the engine's registered select.
module fruit_circle_hit
  import fruit_pkg::*;
#(
  parameter int RADIUS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               active,
  input  logic signed [11:0] x,
  input  logic signed [10:0] y,
  output logic               hit
);
  localparam logic signed [26:0] R2 = 27'(RADIUS * RADIUS);

  logic signed [12:0] dx, dy;
  logic               act_q;
  logic signed [26:0] dx_w, dy_w, d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      dx    <= '0;
      dy    <= '0;
      act_q <= 1'b0;
    end else begin
      act_q <= active;
      dx    <= $signed({2'b00, hcount}) - 13'(x);
      dy    <= $signed({3'b000, vcount}) - 13'(y);
    end
  end

  assign dx_w = 27'(dx);
  assign dy_w = 27'(dy);
  assign d2   = dx_w * dx_w + dy_w * dy_w;
  assign hit  = act_q && (d2 <= R2);

endmodule

// File: rtl/fruit_engine.sv
// Fruit slot store, once-per-frame ballistic/slice/leave update and
// 2-cycle circle renderer for the game layer.
module fruit_engine
  import fruit_pkg::*;
#(
  parameter int NUM_FRUITS = 4,
  parameter int RADIUS     = 16,
  parameter int GRAVITY    = 1,
  parameter int SCREEN_W   = 1280,
  parameter int SCREEN_H   = 720
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  new_frame_in,
  input  logic                  spawn_valid_in,
  output logic                  spawn_ready_out,
  input  logic [10:0]           spawn_x_in,
  input  logic signed [4:0]     spawn_vx_in,
  input  logic signed [5:0]     spawn_vy_in,
  input  logic [11:0]           spawn_color_in,
  input  logic                  blade_valid_in,
  input  logic [10:0]           blade_x_in,
  input  logic [9:0]            blade_y_in,
  output logic [11:0]           game_pixel_out,
  output logic                  sliced_out,
  output logic                  missed_out,
  output logic [7:0]            slice_count_out,
  output logic [NUM_FRUITS-1:0] active_out
);
  localparam int IDXW = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1;
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NUM_FRUITS - 1);
  localparam logic signed [11:0] X_END  = 12'(SCREEN_W);
  localparam logic signed [10:0] Y_LAST = 11'(SCREEN_H - 1);
  localparam logic signed [6:0]  VY_MAX = 7'sd31;

  fruit_t          slot [NUM_FRUITS];
  state_t          state;
  logic [IDXW-1:0] idx;
  logic            bv;
  logic [10:0]     bx;
  logic [9:0]      by;

  logic            any_free;
  logic [IDXW-1:0] free_idx;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_FRUITS - 1; i >= 0; i--)
      if (!slot[i].active) begin
        any_free = 1'b1;
        free_idx = IDXW'(i);
      end
  end

  assign spawn_ready_out = (state == IDLE) && any_free && !rst_in;

  fruit_t             cur, spawn_f;
  logic signed [12:0] sdx, sdy;
  logic signed [11:0] nx;
  logic signed [10:0] ny;
  logic signed [6:0]  vy_sum;
  logic signed [5:0]  nvy;
  logic               slice_hit, leave;

  // Slice test uses the pre-move position against the frame-latched blade.
  always_comb begin
    cur       = slot[idx];
    sdx       = 13'(cur.x) - $signed({2'b00, bx});
    sdy       = 13'(cur.y) - $signed({3'b000, by});
    slice_hit = bv && (abs13(sdx) < 13'(RADIUS)) && (abs13(sdy) < 13'(RADIUS));
    nx        = cur.x + 12'(cur.vx);
    ny        = cur.y + 11'(cur.vy);
    vy_sum    = 7'(cur.vy) + 7'(GRAVITY);
    nvy       = (vy_sum > VY_MAX) ? 6'sd31 : vy_sum[5:0];
    leave     = (nx < 12'sd0) || (nx >= X_END) || ((ny > Y_LAST) && (nvy > 6'sd0));

    spawn_f.active = 1'b1;
    spawn_f.x      = {1'b0, spawn_x_in};
    spawn_f.y      = Y_LAST;
    spawn_f.vx     = 6'(spawn_vx_in);
    spawn_f.vy     = spawn_vy_in;
    spawn_f.colour = (spawn_color_in == TRANSPARENT) ? COLOR_FIX : spawn_color_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      idx             <= '0;
      bv              <= 1'b0;
      bx              <= '0;
      by              <= '0;
      sliced_out      <= 1'b0;
      missed_out      <= 1'b0;
      slice_count_out <= '0;
      for (int i = 0; i < NUM_FRUITS; i++) slot[i] <= '0;
    end else begin
      sliced_out <= 1'b0;
      missed_out <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn_valid_in && spawn_ready_out) slot[free_idx] <= spawn_f;
          if (new_frame_in) begin
            bv    <= blade_valid_in;
            bx    <= blade_x_in;
            by    <= blade_y_in;
            idx   <= '0;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (cur.active) begin
            if (slice_hit) begin
              slot[idx].active <= 1'b0;
              sliced_out       <= 1'b1;
              if (slice_count_out != 8'hFF) slice_count_out <= slice_count_out + 8'd1;
            end else begin
              slot[idx].x  <= nx;
              slot[idx].y  <= ny;
              slot[idx].vy <= nvy;
              if (leave) begin
                slot[idx].active <= 1'b0;
                missed_out       <= 1'b1;
              end
            end
          end
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NUM_FRUITS-1:0] hit;

  for (genvar g = 0; g < NUM_FRUITS; g++) begin : g_slot
    fruit_circle_hit #(.RADIUS(RADIUS)) u_hit (
      .clk    (clk_in),
      .rst    (rst_in),
      .hcount (hcount_in),
      .vcount (vcount_in),
      .active (slot[g].active),
      .x      (slot[g].x),
      .y      (slot[g].y),
      .hit    (hit[g])
    );
    assign active_out[g] = slot[g].active;
  end

  logic [11:0] pix;

  // Lowest-index covering slot wins.
  always_comb begin
    pix = TRANSPARENT;
    for (int i = NUM_FRUITS - 1; i >= 0; i--)
      if (hit[i]) pix = slot[i].colour;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) game_pixel_out <= TRANSPARENT;
    else        game_pixel_out <= pix;
  end

endmodule

// File: tb/tb_fruit_engine.sv
// Randomized bench for fruit_engine against a frame-level reference model.
module tb_fruit_engine;
  localparam int N  = 4;
  localparam int R  = 16;
  localparam int SW = 1280;
  localparam int SH = 720;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [10:0]       hcount = '0;
  logic [9:0]        vcount = '0;
  logic              new_frame = 1'b0;
  logic              spawn_valid = 1'b0;
  logic              spawn_ready;
  logic [10:0]       spawn_x = '0;
  logic signed [4:0] spawn_vx = '0;
  logic signed [5:0] spawn_vy = '0;
  logic [11:0]       spawn_color = '0;
  logic              blade_valid = 1'b0;
  logic [10:0]       blade_x = '0;
  logic [9:0]        blade_y = '0;
  logic [11:0]       game_pixel;
  logic              sliced, missed;
  logic [7:0]        slice_count;
  logic [N-1:0]      active;

  always #5 clk = ~clk;

  fruit_engine #(.NUM_FRUITS(N), .RADIUS(R), .GRAVITY(1), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .new_frame_in(new_frame), .spawn_valid_in(spawn_valid), .spawn_ready_out(spawn_ready),
    .spawn_x_in(spawn_x), .spawn_vx_in(spawn_vx), .spawn_vy_in(spawn_vy),
    .spawn_color_in(spawn_color), .blade_valid_in(blade_valid), .blade_x_in(blade_x),
    .blade_y_in(blade_y), .game_pixel_out(game_pixel), .sliced_out(sliced),
    .missed_out(missed), .slice_count_out(slice_count), .active_out(active)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Reference model: one entry per slot, plain integers.
  int m_act[N], m_x[N], m_y[N], m_vx[N], m_vy[N], m_col[N], ev[N];
  int m_cnt = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  function automatic int m_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_act[i]) m |= (1 << i);
    return m;
  endfunction

  function automatic int m_pix(input int h, input int v);
    for (int i = 0; i < N; i++)
      if (m_act[i] && ((h - m_x[i]) * (h - m_x[i]) + (v - m_y[i]) * (v - m_y[i]) <= R * R))
        return m_col[i];
    return 0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_act[i] = 0;
    m_cnt = 0;
  endtask

  task automatic m_load(input int f, input int x, input int vx, input int vy, input int col);
    m_act[f] = 1; m_x[f] = x; m_y[f] = SH - 1; m_vx[f] = vx; m_vy[f] = vy;
    m_col[f] = (col == 0) ? 'h111 : col;
  endtask

  task automatic m_frame(input int bv, input int bx, input int by);
    for (int i = 0; i < N; i++) begin
      ev[i] = 0;
      if (!m_act[i]) continue;
      if (bv && iabs(m_x[i] - bx) < R && iabs(m_y[i] - by) < R) begin
        m_act[i] = 0; ev[i] = 1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_x[i] += m_vx[i];
        m_y[i] += m_vy[i];
        m_vy[i] = (m_vy[i] + 1 > 31) ? 31 : m_vy[i] + 1;
        if (m_x[i] < 0 || m_x[i] >= SW || (m_y[i] > SH - 1 && m_vy[i] > 0)) begin
          m_act[i] = 0; ev[i] = 2;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_spawn(input int x, input int vx, input int vy, input int col);
    spawn_x = x[10:0]; spawn_vx = vx[4:0]; spawn_vy = vy[5:0]; spawn_color = col[11:0];
  endtask

  task automatic spawn(input int x, input int vx, input int vy, input int col);
    int f = m_free();
    drive_spawn(x, vx, vy, col);
    spawn_valid = 1'b1;
    chk("spawn_ready", spawn_ready, f >= 0);
    tick();
    spawn_valid = 1'b0;
    if (f >= 0) m_load(f, x, vx, vy, col);
  endtask

  task automatic frame(input int bv, input int bx, input int by, input int sp,
                       input int sx, input int svx, input int svy, input int scol);
    int f = -1;
    new_frame = 1'b1; blade_valid = bv[0]; blade_x = bx[10:0]; blade_y = by[9:0];
    if (sp) begin
      f = m_free();
      drive_spawn(sx, svx, svy, scol);
      spawn_valid = 1'b1;
      chk("ready_nf", spawn_ready, f >= 0);
    end
    tick();
    new_frame = 1'b0; spawn_valid = 1'b0; blade_valid = 1'b0;
    blade_x = 11'($urandom); blade_y = 10'($urandom);
    if (sp && f >= 0) m_load(f, sx, svx, svy, scol);
    m_frame(bv, bx, by);
    for (int i = 0; i < N; i++) begin
      chk("ready_upd", spawn_ready, 0);
      new_frame = (i == 1);
      tick();
      chk("sliced", sliced, ev[i] == 1);
      chk("missed", missed, ev[i] == 2);
    end
    new_frame = 1'b0;
    chk("active", active, m_mask());
    chk("count", slice_count, m_cnt);
    chk("ready_idle", spawn_ready, m_free() >= 0);
  endtask

  // exp < 0 selects the model's rendering.
  task automatic pix(input int h, input int v, input int exp);
    int e;
    if (h < 0) h = 0;
    if (h > 2047) h = 2047;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    hcount = h[10:0]; vcount = v[9:0];
    tick(); tick();
    e = (exp < 0) ? m_pix(h, v) : exp;
    chk("pixel", game_pixel, e);
  endtask

  initial begin
    int k, b, t;
    m_clear();
    repeat (3) tick();
    chk("ready_rst", spawn_ready, 0);
    rst = 1'b0;
    chk("active_rst", active, 0);
    chk("count_rst", slice_count, 0);
    chk("pix_rst", game_pixel, 0);
    chk("sliced_rst", sliced, 0);
    chk("missed_rst", missed, 0);

    frame(0, 0, 0, 0, 0, 0, 0, 0);
    pix(640, 360, 0);

    spawn(640, 0, -20, 'hF00);
    frame(0, 0, 0, 0, 0, 0, 0, 0);
    pix(640, 700, 'hF00);
    pix(657, 700, 0);
    pix(640, 683, 'hF00);
    pix(640, 682, 0);

    spawn(200, 1, -25, 'h0F0);
    spawn(400, -1, -22, 'h00F);
    spawn(900, 2, -24, 'h000);
    chk("full_mask", active, 'hF);
    pix(900, 719, 'h111);
    spawn(50, 3, -10, 'hAAA);
    drive_spawn(60, 1, -9, 'hBBB);
    spawn_valid = 1'b1;
    repeat (3) begin
      chk("ready_full", spawn_ready, 0);
      tick();
    end
    spawn_valid = 1'b0;
    chk("full_keep", active, 'hF);
    for (int i = 0; i < N; i++) pix(m_x[i], m_y[i], -1);

    frame(1, m_x[0] - 5, m_y[0] - 5, 0, 0, 0, 0, 0);
    pix(640, 699, -1);
    frame(1, m_x[1] + 16, m_y[1], 0, 0, 0, 0, 0);
    frame(1, m_x[1] + 15, m_y[1] - 15, 0, 0, 0, 0, 0);

    // Abort an update pass with reset while a fruit is on the pixel pipeline.
    k = 0;
    for (int i = N - 1; i >= 0; i--) if (m_act[i]) k = i;
    pix(m_x[k], m_y[k], -1);
    new_frame = 1'b1; tick(); new_frame = 1'b0; tick();
    rst = 1'b1; tick();
    chk("abort_pix", game_pixel, 0);
    chk("abort_active", active, 0);
    chk("abort_count", slice_count, 0);
    chk("abort_sliced", sliced, 0);
    chk("abort_ready", spawn_ready, 0);
    rst = 1'b0; m_clear(); tick();
    chk("abort_pix2", game_pixel, 0);
    frame(0, 0, 0, 0, 0, 0, 0, 0);

    spawn(100, 3, 10, 'hABC);
    frame(0, 0, 0, 0, 0, 0, 0, 0);
    spawn(1275, 8, -5, 'h123);
    frame(0, 0, 0, 0, 0, 0, 0, 0);
    spawn(5, -8, -5, 'h321);
    frame(0, 0, 0, 0, 0, 0, 0, 0);
    spawn(700, 0, 0, 'h456);
    frame(0, 0, 0, 0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0, 0, 0, 0);

    spawn(500, 0, -10, 'h0F0);
    spawn(510, 0, -10, 'h00F);
    pix(505, 719, 'h0F0);
    pix(515, 719, 'h0F0);
    pix(520, 719, 'h00F);
    spawn(800, 0, -10, 'h000);
    pix(800, 719, 'h111);

    for (int it = 0; it < 100; it++) begin
      while (m_free() >= 0) spawn(300, 0, -1, 'h5A5);
      frame(1, 300, 719, 0, 0, 0, 0, 0);
    end
    chk("count_sat", slice_count, 255);

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 1) != 0)
        spawn($urandom_range(0, SW - 1), $urandom_range(0, 31) - 16,
              $urandom_range(0, 63) - 32, $urandom_range(0, 4095));
      k = $urandom_range(0, N - 1);
      b = $urandom_range(0, 3);
      t = $urandom_range(0, 3);
      if (b < 2 && m_act[k])
        frame(1, m_x[k] + $urandom_range(0, 34) - 17, m_y[k] + $urandom_range(0, 34) - 17,
              t == 0, $urandom_range(0, SW - 1), $urandom_range(0, 31) - 16,
              $urandom_range(0, 63) - 32, $urandom_range(0, 4095));
      else
        frame(b == 2, $urandom_range(0, SW - 1), $urandom_range(0, SH - 1),
              t == 0, $urandom_range(0, SW - 1), $urandom_range(0, 31) - 16,
              $urandom_range(0, 63) - 32, $urandom_range(0, 4095));
      k = $urandom_range(0, N - 1);
      if (m_act[k]) pix(m_x[k] + $urandom_range(0, 36) - 18, m_y[k] + $urandom_range(0, 36) - 18, -1);
      pix($urandom_range(0, SW - 1), $urandom_range(0, SH - 1), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
